// File: rtl/control_unit.sv
// control_unit: multi-cycle Moore controller for a small 16-bit datapath.
// Sequences FETCH / DECODE / execute, owns the PC and instruction register,
// and decodes every memory and register-file strobe from the state code.
// Optional build macro: CU_LOGIC_OPS_EN adds AND/OR/XOR (opcodes 6, 7, 8).
module control_unit (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] Instr_Data,
    output logic [6:0]  PC_Addr,
    output logic [15:0] IR_Out,
    output logic [7:0]  D_Addr,
    output logic        D_Rd,
    output logic        D_Wr,
    output logic [3:0]  RF_Ra_Addr,
    output logic [3:0]  RF_Rb_Addr,
    output logic [3:0]  RF_W_Addr,
    output logic        RF_W_en,
    output logic        RF_s,
    output logic [2:0]  ALU_Sel,
    output logic [3:0]  State_Out,
    output logic        Halted
);

    localparam logic [3:0] S_INIT   = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_NOOP   = 4'd3;
    localparam logic [3:0] S_LOAD_A = 4'd4;
    localparam logic [3:0] S_LOAD_B = 4'd5;
    localparam logic [3:0] S_STORE  = 4'd6;
    localparam logic [3:0] S_ADD    = 4'd7;
    localparam logic [3:0] S_SUB    = 4'd8;
    localparam logic [3:0] S_HALT   = 4'd9;
`ifdef CU_LOGIC_OPS_EN
    localparam logic [3:0] S_AND    = 4'd10;
    localparam logic [3:0] S_OR     = 4'd11;
    localparam logic [3:0] S_XOR    = 4'd12;
`endif

    logic [3:0]  state_reg;
    logic [3:0]  state_next;
    logic [6:0]  pc_reg;
    logic [15:0] ir_reg;

    logic [3:0]  opcode;
    logic [3:0]  ra_field;
    logic [3:0]  rb_field;
    logic [3:0]  rc_field;
    logic [7:0]  mem_addr;
    logic [3:0]  mem_reg;

    // Instruction fields; ALU and memory formats overlap on the same bits.
    assign opcode   = ir_reg[15:12];
    assign ra_field = ir_reg[11:8];
    assign rb_field = ir_reg[7:4];
    assign rc_field = ir_reg[3:0];
    assign mem_addr = ir_reg[11:4];
    assign mem_reg  = ir_reg[3:0];

    // State, PC and IR registers; IR capture and PC increment share the FETCH edge.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_reg <= S_INIT;
            pc_reg    <= 7'd0;
            ir_reg    <= 16'd0;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_FETCH) begin
                ir_reg <= Instr_Data;
                pc_reg <= pc_reg + 7'd1;  // natural 7-bit wrap 127 -> 0
            end
        end
    end

    // Next-state logic: DECODE dispatches on the opcode, unknown opcodes run as NOOP.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_INIT:   state_next = S_FETCH;
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    4'd0:    state_next = S_NOOP;
                    4'd1:    state_next = S_STORE;
                    4'd2:    state_next = S_LOAD_A;
                    4'd3:    state_next = S_ADD;
                    4'd4:    state_next = S_SUB;
                    4'd5:    state_next = S_HALT;
`ifdef CU_LOGIC_OPS_EN
                    4'd6:    state_next = S_AND;
                    4'd7:    state_next = S_OR;
                    4'd8:    state_next = S_XOR;
`endif
                    default: state_next = S_NOOP;
                endcase
            end
            S_LOAD_A: state_next = S_LOAD_B;
            S_NOOP:   state_next = S_FETCH;
            S_LOAD_B: state_next = S_FETCH;
            S_STORE:  state_next = S_FETCH;
            S_ADD:    state_next = S_FETCH;
            S_SUB:    state_next = S_FETCH;
`ifdef CU_LOGIC_OPS_EN
            S_AND:    state_next = S_FETCH;
            S_OR:     state_next = S_FETCH;
            S_XOR:    state_next = S_FETCH;
`endif
            S_HALT:   state_next = S_HALT;
            default:  state_next = S_INIT;
        endcase
    end

    // Moore outputs from state alone; write strobes are additionally masked by Reset.
    always_comb begin
        D_Addr     = 8'd0;
        D_Rd       = 1'b0;
        D_Wr       = 1'b0;
        RF_Ra_Addr = 4'd0;
        RF_Rb_Addr = 4'd0;
        RF_W_Addr  = 4'd0;
        RF_W_en    = 1'b0;
        RF_s       = 1'b0;
        ALU_Sel    = 3'd0;
        case (state_reg)
            S_LOAD_A: begin
                D_Addr = mem_addr;
                D_Rd   = 1'b1;
            end
            S_LOAD_B: begin
                D_Addr    = mem_addr;
                D_Rd      = 1'b1;
                RF_s      = 1'b1;
                RF_W_en   = 1'b1;
                RF_W_Addr = mem_reg;
            end
            S_STORE: begin
                D_Addr     = mem_addr;
                D_Wr       = 1'b1;
                RF_Ra_Addr = mem_reg;
            end
            S_ADD, S_SUB
`ifdef CU_LOGIC_OPS_EN
            , S_AND, S_OR, S_XOR
`endif
            : begin
                RF_Ra_Addr = ra_field;
                RF_Rb_Addr = rb_field;
                RF_W_Addr  = rc_field;
                RF_W_en    = 1'b1;
                case (state_reg)
                    S_SUB:   ALU_Sel = 3'd1;
`ifdef CU_LOGIC_OPS_EN
                    S_AND:   ALU_Sel = 3'd4;
                    S_OR:    ALU_Sel = 3'd5;
                    S_XOR:   ALU_Sel = 3'd6;
`endif
                    default: ALU_Sel = 3'd0;
                endcase
            end
            default: ;
        endcase
        // A reset landing mid-instruction must not commit a memory or register write.
        if (Reset) begin
            D_Wr    = 1'b0;
            RF_W_en = 1'b0;
        end
    end

    assign PC_Addr   = pc_reg;
    assign IR_Out    = ir_reg;
    assign State_Out = state_reg;
    assign Halted    = (state_reg == S_HALT);

endmodule

// File: tb/tb_control_unit.sv
// Directed, table-driven bench for control_unit.
// Outputs are sampled on the falling edge; inputs change there too.
module tb_control_unit;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [15:0] Instr_Data;
    logic [6:0]  PC_Addr;
    logic [15:0] IR_Out;
    logic [7:0]  D_Addr;
    logic        D_Rd, D_Wr;
    logic [3:0]  RF_Ra_Addr, RF_Rb_Addr, RF_W_Addr;
    logic        RF_W_en, RF_s;
    logic [2:0]  ALU_Sel;
    logic [3:0]  State_Out;
    logic        Halted;

    int n_cmp  = 0;
    int n_fail = 0;

    control_unit dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Instr_Data (Instr_Data),
        .PC_Addr    (PC_Addr),
        .IR_Out     (IR_Out),
        .D_Addr     (D_Addr),
        .D_Rd       (D_Rd),
        .D_Wr       (D_Wr),
        .RF_Ra_Addr (RF_Ra_Addr),
        .RF_Rb_Addr (RF_Rb_Addr),
        .RF_W_Addr  (RF_W_Addr),
        .RF_W_en    (RF_W_en),
        .RF_s       (RF_s),
        .ALU_Sel    (ALU_Sel),
        .State_Out  (State_Out),
        .Halted     (Halted)
    );

    always #5 Clock = ~Clock;

    // Output bundle: {D_Addr, D_Rd, D_Wr, Ra, Rb, W, W_en, s, ALU_Sel} = 27 bits
    typedef struct {
        logic [15:0] instr;
        logic [3:0]  st;     // final execute state
        logic [26:0] outs;   // outputs expected in that state
    } vec_t;

    vec_t vecs [10];
    localparam int NOOP_IDX = 9;

    function automatic logic [26:0] outs_now();
        return {D_Addr, D_Rd, D_Wr, RF_Ra_Addr, RF_Rb_Addr, RF_W_Addr, RF_W_en, RF_s, ALU_Sel};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Runs one instruction starting at a falling edge where the FSM sits in FETCH.
    task automatic run_vec(input int i, input bit verbose);
        logic [6:0]  pc_exp;
        logic [26:0] la;
        chk("fetch_state", 32'(State_Out), 32'd1);
        chk("fetch_outs", 32'(outs_now()), 32'd0);
        pc_exp     = PC_Addr + 7'd1;
        Instr_Data = vecs[i].instr;
        @(negedge Clock);
        chk("decode_state", 32'(State_Out), 32'd2);
        chk("ir_load", 32'(IR_Out), 32'(vecs[i].instr));
        chk("pc_inc", 32'(PC_Addr), 32'(pc_exp));
        chk("decode_outs", 32'(outs_now()), 32'd0);
        Instr_Data = 16'hFFFF;
        if (vecs[i].st == 4'd5) begin
            @(negedge Clock);
            la = {vecs[i].outs[26:19], 1'b1, 18'd0};
            chk("load_a_state", 32'(State_Out), 32'd4);
            chk("load_a_outs", 32'(outs_now()), 32'(la));
        end
        @(negedge Clock);
        chk("exec_state", 32'(State_Out), 32'(vecs[i].st));
        chk("exec_outs", 32'(outs_now()), 32'(vecs[i].outs));
        chk("exec_halted", 32'(Halted), 32'd0);
        chk("exec_pc", 32'(PC_Addr), 32'(pc_exp));
        @(negedge Clock);
        chk("back_to_fetch", 32'(State_Out), 32'd1);
        if (verbose)
            $display("vec %0d instr %h exec_state %0d pc %0d", i, vecs[i].instr, vecs[i].st, PC_Addr);
    endtask

    // Drives an instruction until the FSM reaches state st, then resets there.
    task automatic abort_in(input logic [15:0] instr, input logic [3:0] st);
        int k;
        Instr_Data = instr;
        k = 0;
        while (State_Out != st && k < 8) begin
            @(negedge Clock);
            k++;
        end
        chk("abort_reach", 32'(State_Out), 32'(st));
        Reset = 1'b1;
        #1;
        chk("reset_mask_wr", 32'(D_Wr), 32'd0);
        chk("reset_mask_wen", 32'(RF_W_en), 32'd0);
        @(negedge Clock);
        chk("abort_init", 32'(State_Out), 32'd0);
        chk("abort_pc", 32'(PC_Addr), 32'd0);
        chk("abort_ir", 32'(IR_Out), 32'd0);
        Reset = 1'b0;
        @(negedge Clock);
        chk("abort_fetch", 32'(State_Out), 32'd1);
        $display("abort instr %h in state %0d", instr, st);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{16'h2053, 4'd5,  {8'h05, 1'b1, 1'b0, 4'd0, 4'd0, 4'd3, 1'b1, 1'b1, 3'd0}};
        vecs[1] = '{16'h3124, 4'd7,  {8'h00, 1'b0, 1'b0, 4'd1, 4'd2, 4'd4, 1'b1, 1'b0, 3'd0}};
        vecs[2] = '{16'h4124, 4'd8,  {8'h00, 1'b0, 1'b0, 4'd1, 4'd2, 4'd4, 1'b1, 1'b0, 3'd1}};
        vecs[3] = '{16'h10A7, 4'd6,  {8'h0A, 1'b0, 1'b1, 4'd7, 4'd0, 4'd0, 1'b0, 1'b0, 3'd0}};
        vecs[4] = '{16'h0FFF, 4'd3,  27'd0};
`ifdef CU_LOGIC_OPS_EN
        vecs[5] = '{16'h6124, 4'd10, {8'h00, 1'b0, 1'b0, 4'd1, 4'd2, 4'd4, 1'b1, 1'b0, 3'd4}};
        vecs[6] = '{16'h7124, 4'd11, {8'h00, 1'b0, 1'b0, 4'd1, 4'd2, 4'd4, 1'b1, 1'b0, 3'd5}};
        vecs[7] = '{16'h8124, 4'd12, {8'h00, 1'b0, 1'b0, 4'd1, 4'd2, 4'd4, 1'b1, 1'b0, 3'd6}};
`else
        vecs[5] = '{16'h6124, 4'd3,  27'd0};
        vecs[6] = '{16'h7124, 4'd3,  27'd0};
        vecs[7] = '{16'h8124, 4'd3,  27'd0};
`endif
        vecs[8] = '{16'hF555, 4'd3,  27'd0};
        vecs[9] = '{16'h0000, 4'd3,  27'd0};

        // Reset held for two cycles, then released.
        Reset      = 1'b1;
        Instr_Data = 16'h0000;
        for (int c = 0; c < 2; c++) begin
            @(negedge Clock);
            chk("reset_state", 32'(State_Out), 32'd0);
            chk("reset_pc", 32'(PC_Addr), 32'd0);
            chk("reset_ir", 32'(IR_Out), 32'd0);
            chk("reset_outs", 32'(outs_now()), 32'd0);
            chk("reset_halted", 32'(Halted), 32'd0);
        end
        Reset = 1'b0;
        @(negedge Clock);
        chk("post_reset_fetch", 32'(State_Out), 32'd1);
        $display("reset released, state %0d", State_Out);

        for (int i = 0; i < 10; i++) run_vec(i, 1'b1);

        // Walk PC up to 127 with NOOPs, then check wrap on the next fetch.
        for (int k = 0; k < 130 && PC_Addr != 7'd127; k++) run_vec(NOOP_IDX, 1'b0);
        chk("pc_reach_127", 32'(PC_Addr), 32'd127);
        run_vec(NOOP_IDX, 1'b1);
        chk("pc_wrap", 32'(PC_Addr), 32'd0);

        // HALT holds state, PC and IR with no strobes.
        Instr_Data = 16'h5000;
        @(negedge Clock);
        Instr_Data = 16'h3124;
        @(negedge Clock);
        for (int c = 0; c < 20; c++) begin
            chk("halt_state", 32'(State_Out), 32'd9);
            chk("halt_flag", 32'(Halted), 32'd1);
            chk("halt_outs", 32'(outs_now()), 32'd0);
            chk("halt_pc", 32'(PC_Addr), 32'd1);
            chk("halt_ir", 32'(IR_Out), 32'h5000);
            @(negedge Clock);
        end
        $display("halt held 20 cycles, state %0d", State_Out);
        Reset = 1'b1;
        @(negedge Clock);
        chk("halt_reset_state", 32'(State_Out), 32'd0);
        chk("halt_reset_flag", 32'(Halted), 32'd0);
        chk("halt_reset_ir", 32'(IR_Out), 32'd0);
        Reset = 1'b0;
        @(negedge Clock);
        chk("halt_reset_fetch", 32'(State_Out), 32'd1);

        // Reset arriving mid-instruction.
        abort_in(16'h2053, 4'd4);
        abort_in(16'h3124, 4'd7);
        abort_in(16'h10A7, 4'd6);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
